// File: rtl/elevator_request_queue.sv
// elevator_request_queue: latches hall/car calls and runs SCAN to pick the next target floor (optional REQ_IDLE_HOME_EN parks the car at HOME_FLOOR when idle)
module elevator_request_queue #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_BITS    = 3,
    parameter int HOME_FLOOR    = 0,
    parameter int HOME_DELAY    = 50
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BUTTONS_WIDTH-1:0] btn_in,
    input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
    input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
    input  logic [FLOOR_BITS-1:0]    current_floor,
    input  logic                     serve,
    output logic [BUTTONS_WIDTH-1:0] pending_car,
    output logic [BUTTONS_WIDTH-1:0] pending_up,
    output logic [BUTTONS_WIDTH-1:0] pending_down,
    output logic [FLOOR_BITS-1:0]    target_floor,
    output logic                     target_valid,
    output logic [1:0]               dir
);
    typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} dir_t;
    localparam logic [BUTTONS_WIDTH-1:0] UP_MASK   = {1'b0, {(BUTTONS_WIDTH-1){1'b1}}};
    localparam logic [BUTTONS_WIDTH-1:0] DOWN_MASK = {{(BUTTONS_WIDTH-1){1'b1}}, 1'b0};
    if (HOME_FLOOR >= BUTTONS_WIDTH || HOME_DELAY < 1 || (1 << FLOOR_BITS) < BUTTONS_WIDTH) begin : g_bad_params
        $error("elevator_request_queue: inconsistent parameters");
    end
    dir_t state, state_nxt;
    logic [BUTTONS_WIDTH-1:0] car_nxt, up_nxt, down_nxt, served, home_set, pending_all;
    logic [FLOOR_BITS-1:0] target_nxt, up_first, up_far, down_first, down_far;
    logic any_above, any_below, here, has_up_first, has_down_first;
    assign served      = serve ? BUTTONS_WIDTH'(1) << current_floor : '0;
    assign pending_all = pending_car | pending_up | pending_down;
    assign dir         = state;
`ifdef REQ_IDLE_HOME_EN
    localparam int CW = $clog2(HOME_DELAY + 1);
    logic [CW-1:0] home_cnt;
    logic home_idle;
    assign home_idle = state == IDLE && pending_all == '0 && ~|{btn_in, btn_up_out, btn_down_out} &&
                       current_floor != FLOOR_BITS'(HOME_FLOOR);
    assign home_set  = (home_idle && home_cnt == CW'(HOME_DELAY - 1)) ? BUTTONS_WIDTH'(1) << HOME_FLOOR : '0;
    // idle timer: restarts on any activity or at home, and again once it has fired
    always_ff @(posedge clk) begin
        if (reset || !home_idle || home_set != '0) home_cnt <= '0;
        else home_cnt <= home_cnt + 1'b1;
    end
`else
    assign home_set = '0;
`endif
    // locate requests relative to the car: nearest/farthest in each direction
    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        here = 1'b0;
        has_up_first = 1'b0;
        has_down_first = 1'b0;
        up_first = current_floor;
        up_far = current_floor;
        down_first = current_floor;
        down_far = current_floor;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (pending_all[i]) begin
                if (i > int'(current_floor)) any_above = 1'b1;
                else if (i < int'(current_floor)) any_below = 1'b1;
                else here = 1'b1;
            end
            if (i > int'(current_floor) && pending_down[i]) up_far = FLOOR_BITS'(i);
            if (i < int'(current_floor) && (pending_car[i] || pending_down[i])) begin
                down_first = FLOOR_BITS'(i);
                has_down_first = 1'b1;
            end
        end
        for (int i = BUTTONS_WIDTH - 1; i >= 0; i--) begin
            if (i > int'(current_floor) && (pending_car[i] || pending_up[i])) begin
                up_first = FLOOR_BITS'(i);
                has_up_first = 1'b1;
            end
            if (i < int'(current_floor) && pending_up[i]) down_far = FLOOR_BITS'(i);
        end
    end
    // SCAN direction choice; the target follows the rules of the direction being entered
    always_comb begin
        state_nxt = (state == DOWN) ? (any_below ? DOWN : any_above ? UP : IDLE)
                                    : (any_above ? UP : any_below ? DOWN : IDLE);
        target_nxt = (state_nxt == UP)   ? (has_up_first ? up_first : up_far) :
                     (state_nxt == DOWN) ? (has_down_first ? down_first : down_far) :
                     here ? current_floor : target_floor;
        car_nxt  = (pending_car | btn_in | home_set) & ~served;
        up_nxt   = (pending_up | btn_up_out) & UP_MASK & ~((state != DOWN) ? served : '0);
        down_nxt = (pending_down | btn_down_out) & DOWN_MASK & ~((state != UP) ? served : '0);
    end
    // request latches, direction and registered target
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_car  <= '0;
            pending_up   <= '0;
            pending_down <= '0;
            state        <= IDLE;
            target_floor <= '0;
            target_valid <= 1'b0;
        end else begin
            pending_car  <= car_nxt;
            pending_up   <= up_nxt;
            pending_down <= down_nxt;
            state        <= state_nxt;
            target_floor <= target_nxt;
            target_valid <= |pending_all;
        end
    end
endmodule

// File: tb/tb_elevator_request_queue.sv
// tb_elevator_request_queue: scoreboard bench comparing the request queue against a floor-list reference model
module tb_elevator_request_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] btn_in = '0, btn_up_out = '0, btn_down_out = '0;
    logic [2:0] current_floor = '0;
    logic serve = 1'b0;
    logic [7:0] pending_car, pending_up, pending_down;
    logic [2:0] target_floor;
    logic target_valid;
    logic [1:0] dir;

    elevator_request_queue dut (
        .clk(clk), .reset(reset), .btn_in(btn_in), .btn_up_out(btn_up_out),
        .btn_down_out(btn_down_out), .current_floor(current_floor), .serve(serve),
        .pending_car(pending_car), .pending_up(pending_up), .pending_down(pending_down),
        .target_floor(target_floor), .target_valid(target_valid), .dir(dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [7:0] car, up, dn;
        int dir, tgt;
        bit v;
    } exp_t;
    exp_t q[$];
    bit done = 1'b0;
    int checks = 0, failures = 0;

    bit [7:0] mc, mu, md;
    int mdir, mtgt;
    bit mv;

    // reference: direction 0 idle, 1 up, 2 down; state advances once per clock edge
    task automatic model_step(input bit r, input bit [7:0] b, input bit [7:0] u, input bit [7:0] d,
                              input int cf, input bit s);
        bit [7:0] all;
        bit above, below, here, found;
        int od, nd;
        if (r) begin
            mc = 0; mu = 0; md = 0; mdir = 0; mtgt = 0; mv = 0;
            return;
        end
        all = mc | mu | md;
        above = 0; below = 0; here = 0; found = 0;
        for (int f = 0; f < 8; f++)
            if (all[f]) begin
                if (f > cf) above = 1;
                if (f < cf) below = 1;
                if (f == cf) here = 1;
            end
        od = mdir;
        if (od == 2) nd = below ? 2 : above ? 1 : 0;
        else nd = above ? 1 : below ? 2 : 0;
        if (nd == 1) begin
            for (int f = cf + 1; f < 8; f++) if (!found && (mc[f] || mu[f])) begin mtgt = f; found = 1; end
            for (int f = 7; f > cf; f--) if (!found && md[f]) begin mtgt = f; found = 1; end
        end else if (nd == 2) begin
            for (int f = cf - 1; f >= 0; f--) if (!found && (mc[f] || md[f])) begin mtgt = f; found = 1; end
            for (int f = 0; f < cf; f++) if (!found && mu[f]) begin mtgt = f; found = 1; end
        end else if (here) mtgt = cf;
        mv = (all != 0);
        mdir = nd;
        mc |= b; mu |= u; md |= d;
        mu[7] = 0; md[0] = 0;
        if (s) begin
            mc[cf] = 0;
            if (od != 2) mu[cf] = 0;
            if (od != 1) md[cf] = 0;
        end
    endtask

    task automatic drive(input bit r, input bit [7:0] b, input bit [7:0] u, input bit [7:0] d,
                         input int cf, input bit s);
        exp_t e;
        @(negedge clk);
        reset = r; btn_in = b; btn_up_out = u; btn_down_out = d;
        current_floor = 3'(cf); serve = s;
        model_step(r, b, u, d, cf, s);
        e.car = mc; e.up = mu; e.dn = md; e.dir = mdir; e.tgt = mtgt; e.v = mv;
        q.push_back(e);
    endtask

    task automatic idle(input int n, input int cf);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, cf, 0);
    endtask

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // monitor: every edge yields one expected snapshot
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("pending_car", int'(pending_car), int'(e.car));
                cmp("pending_up", int'(pending_up), int'(e.up));
                cmp("pending_down", int'(pending_down), int'(e.dn));
                cmp("dir", int'(dir), e.dir);
                cmp("target_valid", int'(target_valid), int'(e.v));
                if (e.v) cmp("target_floor", int'(target_floor), e.tgt);
            end else if (done) begin
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // stimulus: directed scenarios followed by random traffic
    initial begin
        bit [7:0] b, u, d;
        int cf;
        bit r, s;
        drive(1, 8'hff, 8'hff, 8'hff, 0, 1);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 8'h80, 0, 0, 0, 0);
        idle(3, 0);
        idle(1, 7);
        drive(0, 0, 0, 0, 7, 1);
        idle(3, 7);
        drive(1, 0, 0, 0, 2, 0);
        drive(0, 8'h20, 0, 0, 2, 0);
        idle(2, 2);
        drive(0, 0, 0, 8'h08, 2, 0);
        idle(3, 2);
        idle(1, 5);
        drive(0, 0, 0, 0, 5, 1);
        idle(3, 5);
        drive(1, 0, 0, 0, 3, 0);
        drive(0, 0, 8'h80, 8'h01, 3, 0);
        idle(3, 3);
        drive(1, 0, 0, 0, 4, 0);
        drive(0, 8'h10, 0, 0, 4, 0);
        drive(0, 8'h10, 0, 0, 4, 1);
        drive(0, 8'h10, 0, 0, 4, 0);
        idle(2, 4);
        cf = 4;
        for (int k = 0; k < 800; k++) begin
            r = ($urandom_range(0, 99) == 0);
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            u = ($urandom_range(0, 4) == 0) ? 8'($urandom & $urandom) : 8'h00;
            d = ($urandom_range(0, 4) == 0) ? 8'($urandom & $urandom) : 8'h00;
            if ($urandom_range(0, 5) == 0) cf = $urandom_range(0, 7);
            s = ($urandom_range(0, 3) == 0);
            drive(r, b, u, d, cf, s);
        end
        idle(2, cf);
        done = 1'b1;
    end
endmodule

// File: doc/elevator_request_queue.md
Name: elevator_request_queue

Overview:
- Upstream stage of the elevator controller.
- Latches one-cycle button pulses from the car panel (btn_in) and the landing panels (btn_up_out, btn_down_out) into pending-request vectors.
- Runs a SCAN direction state machine and presents one registered target floor to the controller.
- Clears served requests when the controller reports a door opening at a floor.

Parameters:
- BUTTONS_WIDTH, 8: number of floors; one bit per floor in every request vector.
- FLOOR_BITS, 3: width of floor indices; 2^FLOOR_BITS >= BUTTONS_WIDTH.
- HOME_FLOOR, 0: park floor, used only with REQ_IDLE_HOME_EN.
- HOME_DELAY, 50: idle cycles before parking, used only with REQ_IDLE_HOME_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- btn_in  in  BUTTONS_WIDTH  car-panel buttons, bit i = floor i.
- btn_up_out  in  BUTTONS_WIDTH  landing up-call buttons.
- btn_down_out  in  BUTTONS_WIDTH  landing down-call buttons.
- current_floor  in  FLOOR_BITS  floor the car is at or last passed.
- serve  in  1  one-cycle strobe: door opening at current_floor.
- pending_car  out  BUTTONS_WIDTH  latched car requests.
- pending_up  out  BUTTONS_WIDTH  latched up calls.
- pending_down  out  BUTTONS_WIDTH  latched down calls.
- target_floor  out  FLOOR_BITS  next floor to stop at.
- target_valid  out  1  target_floor is meaningful.
- dir  out  2  00 IDLE, 01 UP, 10 DOWN; 11 never driven.

Behaviour:
- Reset: all pending vectors 0, target_floor 0, target_valid 0, dir IDLE. Buttons held high during reset are ignored.
- Latching: any cycle in which a button bit is high sets the matching pending bit at the next edge. Bits are sticky until served.
- Nonexistent landing buttons: btn_up_out[BUTTONS_WIDTH-1] and btn_down_out[0] are ignored; the matching pending bits stay 0.
- Serve at floor f = current_floor clears:
  - pending_car[f] always;
  - pending_up[f] if dir is UP or IDLE;
  - pending_down[f] if dir is DOWN or IDLE.
- Simultaneous set and clear of the same bit: clear wins. A press at the served floor while its door opens is absorbed.
- Pipeline latency: button pulse at edge N -> pending bit at N+1 -> target_floor, target_valid and dir updated at N+2. All outputs are registered.
- any_above: any pending bit in car, up or down at floor > current_floor. any_below: same for floor < current_floor. here: any pending bit at current_floor.
- State IDLE:
  - any_above -> UP;
  - else any_below -> DOWN;
  - else here -> stay IDLE with target = current_floor, valid = 1;
  - else valid = 0.
- State UP:
  - target = lowest floor > current with car or up request;
  - if none, highest floor > current with a down request;
  - if no request above at all: any_below -> DOWN, else -> IDLE.
- State DOWN: mirror of UP. Target = highest floor < current with car or down request; if none, lowest floor < current with an up request; if nothing below: any_above -> UP, else -> IDLE.
- target_valid = 1 whenever any pending bit is set, after the FSM update.
- Direction reversal takes effect one cycle after the last request in the current direction is cleared.
- Reset mid-operation: every state element returns to its reset value at the same edge. No request survives reset.

Optional Feature:
- Macro: REQ_IDLE_HOME_EN.
- With the macro defined:
  - a counter increments every cycle while dir is IDLE, no bits are pending and current_floor != HOME_FLOOR;
  - any press, any pending bit, or reaching HOME_FLOOR resets the counter to 0;
  - when the counter reaches HOME_DELAY, pending_car[HOME_FLOOR] is set and the counter is cleared.
- Without the macro: no counter logic; the car stays parked wherever it is.

Test Plan:
- Reset, current_floor=0, pulse btn_in[7] for 1 cycle -> pending_car=8'h80 next cycle; target_floor=7, target_valid=1, dir=UP one cycle later.
- current_floor=7, pending_car[7] set, serve pulse -> pending_car=0, then dir=IDLE and target_valid=0.
- current_floor=2, dir UP, pending_car[5] set and btn_down_out[3] pulsed -> target stays 5. After serve at 5 -> dir=DOWN, target=3.
- btn_up_out[7] and btn_down_out[0] pulsed -> pending_up and pending_down stay 0, target_valid stays 0.
- btn_in[4] held high through a serve at current_floor=4 -> pending_car[4]=0 on the serve edge, set again on the following edge.
- REQ_IDLE_HOME_EN, HOME_DELAY=5, HOME_FLOOR=0, current_floor=3, idle -> pending_car[0]=1 after exactly 5 idle cycles, then dir=DOWN and target=0. A press during the count restarts it.
